// File: rtl/wm8731_i2c_config_seq_pkg.sv
// rtl/wm8731_i2c_config_seq_pkg.sv - WM8731 register table, entry type and sequencer states
package wm8731_i2c_config_seq_pkg;

    localparam int WM_NUM_REGS = 10;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wm_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BITS,
        ST_ACK,
        ST_STOP,
        ST_GAP,
        ST_DONE,
        ST_ERROR
    } state_t;

    // R8 (sampling control) is left at its post-reset value of 000 (48k normal mode).
    function automatic wm_entry_t wm_init_table(input logic [3:0] idx);
        wm_entry_t e;
        case (idx)
            4'd0:    e = {7'h0F, 9'h000};
            4'd1:    e = {7'h00, 9'h097};
            4'd2:    e = {7'h01, 9'h097};
            4'd3:    e = {7'h02, 9'h079};
            4'd4:    e = {7'h03, 9'h079};
            4'd5:    e = {7'h04, 9'h012};
            4'd6:    e = {7'h05, 9'h000};
            4'd7:    e = {7'h06, 9'h000};
            4'd8:    e = {7'h07, 9'h002};
            4'd9:    e = {7'h09, 9'h001};
            default: e = {7'h00, 9'h000};
        endcase
        return e;
    endfunction

endpackage

// File: rtl/wm8731_i2c_config_seq_if.sv
// rtl/wm8731_i2c_config_seq_if.sv - 2-wire codec control bus (push-pull SCL, open-drain SDA)
interface wm8731_i2c_config_seq_if;
    logic i2c_sclk;
    logic i2c_sdat_oe;
    logic i2c_sdat_i;

    modport master (output i2c_sclk, output i2c_sdat_oe, input i2c_sdat_i);
    modport slave  (input i2c_sclk, input i2c_sdat_oe, output i2c_sdat_i);
endinterface

// File: rtl/wm8731_i2c_config_seq_i2c_byte_tx.sv
// rtl/wm8731_i2c_config_seq_i2c_byte_tx.sv - byte shifter and ACK capture for the sequencer
module wm8731_i2c_config_seq_i2c_byte_tx (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] tx_byte,
    input  logic       shift,
    input  logic       sample,
    input  logic       sda_i,
    output logic       bit_out,
    output logic       last_bit,
    output logic       nack
);
    logic [7:0] shreg;
    logic [2:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg <= 8'd0;
            cnt   <= 3'd0;
            nack  <= 1'b0;
        end else if (load) begin
            shreg <= tx_byte;
            cnt   <= 3'd0;
            nack  <= 1'b0;
        end else begin
            if (shift) begin
                shreg <= {shreg[6:0], 1'b0};
                cnt   <= cnt + 3'd1;
            end
            if (sample) begin
                nack <= sda_i;
            end
        end
    end

    assign bit_out  = shreg[7];
    assign last_bit = (cnt == 3'd7);
endmodule

// File: rtl/wm8731_i2c_config_seq.sv
// rtl/wm8731_i2c_config_seq.sv - WM8731 power-up register sequencer; WM8731_ACK_RETRY_EN adds NACK retries
module wm8731_i2c_config_seq
    import wm8731_i2c_config_seq_pkg::*;
#(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         I2C_HZ   = 100_000,
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    wm8731_i2c_config_seq_if.master        i2c,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [3:0]                     err_idx
);
    localparam int QDIV = (CLK_HZ / (4 * I2C_HZ) > 0) ? CLK_HZ / (4 * I2C_HZ) : 1;
    localparam int QW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [3:0] LAST_IDX = 4'(WM_NUM_REGS - 1);

    state_t        state, state_n;
    logic [QW-1:0] qcnt;
    logic [1:0]    q, q_n;
    logic [3:0]    idx, idx_n;
    logic [1:0]    sel, sel_n;
    logic          tick, load, shift, sample, bit_out, last_bit, nack;
    logic          sclk, sda_oe;
    logic [7:0]    tx_byte;
    wm_entry_t     entry;
`ifdef WM8731_ACK_RETRY_EN
    logic [1:0]    retry, retry_n;

    always_ff @(posedge clk) begin
        if (reset) retry <= 2'd0;
        else       retry <= retry_n;
    end
`endif

    assign busy    = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
    assign done    = (state == ST_DONE);
    assign error   = (state == ST_ERROR);
    assign err_idx = error ? idx : 4'd0;
    assign tick    = busy && (qcnt == QW'(QDIV - 1));
    assign entry   = wm_init_table(idx);
    assign i2c.i2c_sclk    = sclk;
    assign i2c.i2c_sdat_oe = sda_oe;

    // Byte mux follows sel_n so the next byte is ready on the same tick it is loaded.
    always_comb begin
        case (sel_n)
            2'd0:    tx_byte = {DEV_ADDR, 1'b0};
            2'd1:    tx_byte = {entry.addr, entry.data[8]};
            default: tx_byte = entry.data[7:0];
        endcase
    end

    wm8731_i2c_config_seq_i2c_byte_tx u_byte_tx (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .tx_byte  (tx_byte),
        .shift    (shift),
        .sample   (sample),
        .sda_i    (i2c.i2c_sdat_i),
        .bit_out  (bit_out),
        .last_bit (last_bit),
        .nack     (nack)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            qcnt  <= '0;
            q     <= 2'd0;
            idx   <= 4'd0;
            sel   <= 2'd0;
        end else begin
            state <= state_n;
            q     <= q_n;
            idx   <= idx_n;
            sel   <= sel_n;
            qcnt  <= (tick || !busy) ? '0 : qcnt + 1'b1;
        end
    end

    always_comb begin
        state_n = state;
        q_n     = tick ? q + 2'd1 : q;
        idx_n   = idx;
        sel_n   = sel;
        load    = 1'b0;
        shift   = 1'b0;
        sample  = 1'b0;
        sclk    = 1'b1;
        sda_oe  = 1'b0;
`ifdef WM8731_ACK_RETRY_EN
        retry_n = retry;
`endif
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                // IDLE is only reachable through reset, so it always launches the table.
                if (state == ST_IDLE || start) begin
                    state_n = ST_START;
                    q_n     = 2'd0;
                    idx_n   = 4'd0;
                    sel_n   = 2'd0;
`ifdef WM8731_ACK_RETRY_EN
                    retry_n = 2'd0;
`endif
                end
            end
            ST_START: begin
                sda_oe = (q != 2'd0);
                sclk   = (q < 2'd2);
                if (tick && q == 2'd3) begin
                    state_n = ST_BITS;
                    sel_n   = 2'd0;
                    load    = 1'b1;
                end
            end
            ST_BITS: begin
                sclk   = (q == 2'd1) || (q == 2'd2);
                sda_oe = !bit_out;
                if (tick && q == 2'd3) begin
                    if (last_bit) state_n = ST_ACK;
                    else          shift   = 1'b1;
                end
            end
            ST_ACK: begin
                sclk   = (q == 2'd1) || (q == 2'd2);
                sample = tick && (q == 2'd2);
                if (tick && q == 2'd3) begin
                    if (nack || sel == 2'd2) begin
                        state_n = ST_STOP;
                    end else begin
                        state_n = ST_BITS;
                        sel_n   = sel + 2'd1;
                        load    = 1'b1;
                    end
                end
            end
            ST_STOP: begin
                sclk   = (q != 2'd0);
                sda_oe = (q < 2'd2);
                if (tick && q == 2'd3) begin
                    if (!nack) begin
                        state_n = ST_GAP;
                    end else begin
`ifdef WM8731_ACK_RETRY_EN
                        if (retry == 2'd3) begin
                            state_n = ST_ERROR;
                        end else begin
                            retry_n = retry + 2'd1;
                            state_n = ST_GAP;
                        end
`else
                        state_n = ST_ERROR;
`endif
                    end
                end
            end
            ST_GAP: begin
                if (tick && q == 2'd3) begin
                    // A NACK still latched here means the same entry is being retried.
                    if (nack) begin
                        state_n = ST_START;
                    end else if (idx == LAST_IDX) begin
                        state_n = ST_DONE;
                    end else begin
                        state_n = ST_START;
                        idx_n   = idx + 4'd1;
`ifdef WM8731_ACK_RETRY_EN
                        retry_n = 2'd0;
`endif
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_wm8731_i2c_config_seq.sv
// tb/tb_wm8731_i2c_config_seq.sv - scoreboard bench with WM8731 slave model and table reference model
module tb_wm8731_i2c_config_seq;
    localparam int CLK_HZ  = 800_000;
    localparam int I2C_HZ  = 100_000;
    localparam int QDIV    = 2;
    localparam int TXN_CYC = 30 * 4 * QDIV;
    localparam int BUDGET  = 10 * TXN_CYC + 200;
`ifdef WM8731_ACK_RETRY_EN
    localparam int ATTEMPTS = 4;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, done, error;
    logic [3:0] err_idx;

    wm8731_i2c_config_seq_if bus();

    wm8731_i2c_config_seq #(.CLK_HZ(CLK_HZ), .I2C_HZ(I2C_HZ), .DEV_ADDR(7'h1A)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .i2c     (bus),
        .busy    (busy),
        .done    (done),
        .error   (error),
        .err_idx (err_idx)
    );

    always #5 clk = ~clk;

    logic [6:0] ref_addr [10] = '{7'h0F, 7'h00, 7'h01, 7'h02, 7'h03, 7'h04, 7'h05, 7'h06, 7'h07, 7'h09};
    logic [8:0] ref_data [10] = '{9'h000, 9'h097, 9'h097, 9'h079, 9'h079, 9'h012, 9'h000, 9'h000, 9'h002, 9'h001};

    int checks = 0;
    int passed = 0;
    logic [15:0] exp_q [$];
    logic        exp_err;
    logic [3:0]  exp_eidx;
    int          exp_att;

    // open-drain SDA with pull-up; slave model pulls low for ACK
    logic slave_pull = 1'b0;
    wire  scl = bus.i2c_sclk;
    wire  sda = bus.i2c_sdat_i;
    assign bus.i2c_sdat_i = ~bus.i2c_sdat_oe & ~slave_pull;

    logic [6:0] nack_addr = 7'h7F;
    int         nack_left = 0;
    int         attempts = 0;
    int         proto_err = 0;
    int         cap_txn = 5;
    logic [7:0] cap [3];
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    event       wr_ev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // WM8731 slave: decodes START/STOP/bits on negedge samples, acks, logs completed writes
    initial begin
        logic       prev_scl, prev_sda, in_frame, nacked, ack, s, c;
        int         bitcnt, bytecnt, txn_cnt, cur_txn;
        logic [7:0] shreg;
        logic [7:0] bytes_q [3];
        prev_scl = 1'b1; prev_sda = 1'b1; in_frame = 1'b0; nacked = 1'b0;
        bitcnt = 0; bytecnt = 0; txn_cnt = 0; cur_txn = 0; shreg = 8'd0;
        forever begin
            @(negedge clk);
            s = sda;
            c = scl;
            if (reset) begin
                in_frame = 1'b0; slave_pull = 1'b0; bitcnt = 0; bytecnt = 0; txn_cnt = 0;
            end else if (c && prev_scl && s != prev_sda) begin
                if (!s) begin
                    if (in_frame) proto_err++;
                    in_frame = 1'b1; bitcnt = 0; bytecnt = 0; nacked = 1'b0;
                    cur_txn = txn_cnt; txn_cnt++;
                end else begin
                    if (!in_frame || bitcnt > 1) proto_err++;
                    if (in_frame && bytecnt >= 2 && bytes_q[1][7:1] == nack_addr) attempts++;
                    if (in_frame && bytecnt == 3 && !nacked) begin
                        wr_addr = bytes_q[1][7:1];
                        wr_data = {bytes_q[1][0], bytes_q[2]};
                        -> wr_ev;
                    end
                    in_frame = 1'b0;
                end
            end else if (in_frame && c && !prev_scl) begin
                if (bitcnt < 8) begin
                    shreg = {shreg[6:0], s};
                    bitcnt++;
                end else begin
                    bitcnt = 0;
                    bytecnt++;
                end
            end else if (in_frame && !c && prev_scl) begin
                if (bitcnt == 8 && bytecnt < 3) begin
                    bytes_q[bytecnt] = shreg;
                    if (cur_txn == cap_txn) cap[bytecnt] = shreg;
                    ack = 1'b1;
                    if (bytecnt == 0 && shreg != 8'h34) ack = 1'b0;
                    if (bytecnt == 2 && bytes_q[1][7:1] == nack_addr && nack_left > 0) begin
                        ack = 1'b0;
                        nack_left--;
                    end
                    if (!ack) nacked = 1'b1;
                    slave_pull = ack;
                end else begin
                    slave_pull = 1'b0;
                end
            end
            prev_scl = c;
            prev_sda = s;
        end
    end

    // scoreboard monitor: every logged write pops the next expected entry
    initial begin
        logic [15:0] e;
        forever begin
            @(wr_ev);
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_write: got %0h, expected none", {wr_addr, wr_data});
            end else begin
                e = exp_q.pop_front();
                check("write", {16'd0, wr_addr, wr_data}, {16'd0, e});
            end
        end
    end

    // reference: entries in table order; an entry NACKed at least ATTEMPTS times aborts the run
    task automatic model_run(input int nidx, input int ncnt);
        int fails;
        exp_err = 1'b0; exp_eidx = 4'd0; exp_att = 0;
        for (int i = 0; i < 10; i++) begin
            fails = (i == nidx) ? ncnt : 0;
            if (i == nidx) exp_att = (fails >= ATTEMPTS) ? ATTEMPTS : fails + 1;
            if (fails >= ATTEMPTS) begin
                exp_err = 1'b1;
                exp_eidx = 4'(i);
                return;
            end
            exp_q.push_back({ref_addr[i], ref_data[i]});
        end
    endtask

    task automatic arm(input int nidx, input int ncnt);
        nack_addr = (nidx >= 0) ? ref_addr[nidx] : 7'h7F;
        nack_left = ncnt;
        attempts  = 0;
        model_run(nidx, ncnt);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_clears_done", {31'd0, done}, 32'd0);
        check("start_sets_busy", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_end(output int cycles);
        cycles = 0;
        while (!(done || error) && cycles < BUDGET) begin
            @(posedge clk); #1;
            cycles++;
        end
        check("finish_in_budget", {31'd0, done || error}, 32'd1);
    endtask

    task automatic end_checks();
        check("done", {31'd0, done}, {31'd0, !exp_err});
        check("error", {31'd0, error}, {31'd0, exp_err});
        check("err_idx", {28'd0, err_idx}, {28'd0, exp_eidx});
        check("busy_idle", {31'd0, busy}, 32'd0);
        check("sclk_idle", {31'd0, bus.i2c_sclk}, 32'd1);
        check("sda_oe_idle", {31'd0, bus.i2c_sdat_oe}, 32'd0);
        check("exp_q_drained", exp_q.size(), 32'd0);
        check("attempts", attempts, exp_att);
        check("protocol_errors", proto_err, 32'd0);
    endtask

    initial begin
        int cyc;
        int nidx, ncnt;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sclk", {31'd0, bus.i2c_sclk}, 32'd1);
        check("rst_sda_oe", {31'd0, bus.i2c_sdat_oe}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_err_idx", {28'd0, err_idx}, 32'd0);

        // auto-start after reset, clean run, timing and byte check on entry 5 (04:012)
        arm(-1, 0);
        reset = 1'b0;
        @(posedge clk); #1;
        check("auto_start_busy", {31'd0, busy}, 32'd1);
        wait_end(cyc);
        check("done_time_lo", {31'd0, cyc >= 10 * TXN_CYC - 1}, 32'd1);
        check("done_time_hi", {31'd0, cyc <= 10 * TXN_CYC + 2}, 32'd1);
        end_checks();
        check("byte0", {24'd0, cap[0]}, 32'h34);
        check("byte1", {24'd0, cap[1]}, 32'h08);
        check("byte2", {24'd0, cap[2]}, 32'h12);

        // single NACK on entry 6, then persistent NACK on entry 2
        arm(6, 1);
        pulse_start();
        wait_end(cyc);
        end_checks();
        arm(2, 7);
        pulse_start();
        wait_end(cyc);
        end_checks();

        // randomized NACK target and count
        for (int k = 0; k < 3; k++) begin
            nidx = $urandom_range(0, 9);
            ncnt = $urandom_range(1, 5);
            arm(nidx, ncnt);
            pulse_start();
            wait_end(cyc);
            end_checks();
        end

        // start pulse while busy in entry 3 is ignored
        arm(-1, 0);
        pulse_start();
        repeat (3 * TXN_CYC + $urandom_range(10, TXN_CYC - 10)) @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_ignored_busy", {31'd0, busy}, 32'd1);
        wait_end(cyc);
        end_checks();

        // reset mid-byte of entry 5 releases the bus, then the table replays from the top
        arm(-1, 0);
        pulse_start();
        repeat (5 * TXN_CYC + $urandom_range(30, 200)) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_sclk", {31'd0, bus.i2c_sclk}, 32'd1);
        check("midrst_sda_oe", {31'd0, bus.i2c_sdat_oe}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        arm(-1, 0);
        reset = 1'b0;
        wait_end(cyc);
        end_checks();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
